// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register.
// Owns the fetch PC, keeps a single request outstanding to instruction
// memory, absorbs decode stalls and EX redirects.
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetched/perf_discarded.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no request outstanding; issue a fetch of pc_f next edge
// WAIT  | request outstanding; response will be used
// HOLD  | response captured in hold_buf while decode is stalled
// DROP  | request outstanding but a redirect happened; discard response
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_discarded
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DROP} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_f, pc_f_nxt;
  logic [31:0] pc_f_plus4;
  logic [31:0] hold_buf, hold_buf_nxt;
  logic        req_nxt;
  logic [31:0] addr_nxt;
  logic        load;
  logic [31:0] load_instr;
  logic        discard;
  logic [31:0] target;

  // Redirect targets are word aligned; the low two bits are dropped.
  assign target     = pc_target_e & 32'hFFFF_FFFC;
  assign pc_f_plus4 = pc_f + 32'd4;

  // Next-state, request and load/discard decisions.
  always_comb begin
    state_nxt    = state;
    pc_f_nxt     = pc_f;
    hold_buf_nxt = hold_buf;
    req_nxt      = 1'b0;
    addr_nxt     = imem_addr;
    load         = 1'b0;
    load_instr   = hold_buf;
    discard      = 1'b0;
    case (state)
      IDLE: begin
        if (pc_src_e) begin
          pc_f_nxt = target;
        end else begin
          req_nxt   = 1'b1;
          addr_nxt  = pc_f;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (pc_src_e) begin
            discard   = 1'b1;
            pc_f_nxt  = target;
            state_nxt = IDLE;
          end else if (!stall_d) begin
            load       = 1'b1;
            load_instr = imem_rdata;
            state_nxt  = IDLE;
          end else begin
            hold_buf_nxt = imem_rdata;
            state_nxt    = HOLD;
          end
        end else if (pc_src_e) begin
          pc_f_nxt  = target;
          state_nxt = DROP;
        end
      end
      HOLD: begin
        if (pc_src_e) begin
          discard   = 1'b1;
          pc_f_nxt  = target;
          state_nxt = IDLE;
        end else if (!stall_d) begin
          load      = 1'b1;
          state_nxt = IDLE;
        end
      end
      DROP: begin
        if (pc_src_e) begin
          pc_f_nxt = target;
        end
        if (imem_rvalid) begin
          discard   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A delivered instruction always advances the fetch PC, even if a
    // flush wipes it out of IF/ID in the same cycle.
    if (load) begin
      pc_f_nxt = pc_f_plus4;
    end
  end

  // FSM, fetch PC, hold buffer and memory request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc_f      <= RESET_PC;
      hold_buf  <= 32'd0;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      state     <= state_nxt;
      pc_f      <= pc_f_nxt;
      hold_buf  <= hold_buf_nxt;
      imem_req  <= req_nxt;
      imem_addr <= addr_nxt;
    end
  end

  // IF/ID register: flush beats stall beats load; otherwise a bubble.
  // pc_d/pc_plus4_d only change on a real load.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_d    <= NOP_INSTR;
      pc_d       <= 32'd0;
      pc_plus4_d <= 32'd0;
      valid_d    <= 1'b0;
    end else if (flush_d) begin
      instr_d <= NOP_INSTR;
      valid_d <= 1'b0;
    end else if (stall_d) begin
      instr_d <= instr_d;
      valid_d <= valid_d;
    end else if (load) begin
      instr_d    <= load_instr;
      pc_d       <= pc_f;
      pc_plus4_d <= pc_f_plus4;
      valid_d    <= 1'b1;
    end else begin
      instr_d <= NOP_INSTR;
      valid_d <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Event counters; a load overridden by flush is not counted as fetched.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched   <= 32'd0;
      perf_discarded <= 32'd0;
    end else begin
      if (load && !flush_d) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (discard) begin
        perf_discarded <= perf_discarded + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, a hand-written
// redirect/flush sequence, then random stimulus against a reference model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] W0  = 32'h0050_0093;
  localparam logic [31:0] W1  = 32'h00A0_0113;
  localparam logic [31:0] W2  = 32'h0020_81B3;

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_rvalid, stall_d, flush_d, pc_src_e, valid_d;
  logic [31:0] imem_addr, imem_rdata, pc_target_e, instr_d, pc_d, pc_plus4_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .stall_d(stall_d),
    .flush_d(flush_d), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
    .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d)
  );

  typedef struct {
    logic        rst, rv;
    logic [31:0] rdata;
    logic        st, fl, src;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr, instr, pcd, pc4;
    logic        valid;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic rv, logic [31:0] rd, logic st,
                              logic fl, logic src, logic [31:0] tgt,
                              logic req, logic [31:0] addr, logic [31:0] ins,
                              logic [31:0] pcd, logic [31:0] pc4, logic v);
    vec_t t;
    t.rst = r; t.rv = rv; t.rdata = rd; t.st = st; t.fl = fl; t.src = src;
    t.tgt = tgt; t.req = req; t.addr = addr; t.instr = ins; t.pcd = pcd;
    t.pc4 = pc4; t.valid = v;
    return t;
  endfunction

  // Drive one cycle of inputs, let the edge pass, sample at the falling edge.
  task automatic apply(logic r, logic rv, logic [31:0] rd, logic st, logic fl,
                       logic src, logic [31:0] tgt);
    rst = r; imem_rvalid = rv; imem_rdata = rd; stall_d = st; flush_d = fl;
    pc_src_e = src; pc_target_e = tgt;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(string nm, logic req, logic [31:0] addr, logic [31:0] ins,
                     logic [31:0] pcd, logic [31:0] pc4, logic v);
    checks++;
    if (imem_req !== req || imem_addr !== addr || instr_d !== ins ||
        pc_d !== pcd || pc_plus4_d !== pc4 || valid_d !== v) begin
      errors++;
      $display("FAIL %s: got req=%0b addr=%h instr=%h pc_d=%h pc4=%h valid=%0b, expected req=%0b addr=%h instr=%h pc_d=%h pc4=%h valid=%0b",
               nm, imem_req, imem_addr, instr_d, pc_d, pc_plus4_d, valid_d,
               req, addr, ins, pcd, pc4, v);
    end
  endtask

  // Reference model: request/buffer bookkeeping with flags, per-cycle step.
  logic        m_out, m_disc, m_hb;
  logic [31:0] m_pc, m_buf;
  logic        m_req, m_valid;
  logic [31:0] m_addr, m_instr, m_pcd, m_pc4;

  task automatic model_step(logic r, logic rv, logic [31:0] rd, logic st,
                            logic fl, logic src, logic [31:0] tgt);
    logic        deliver;
    logic [31:0] w, ta, dpc;
    if (r) begin
      m_pc = 32'd0; m_out = 0; m_disc = 0; m_hb = 0; m_buf = 0;
      m_req = 0; m_addr = 32'd0; m_instr = NOP; m_pcd = 0; m_pc4 = 0;
      m_valid = 0;
      return;
    end
    ta = tgt & 32'hFFFF_FFFC;
    deliver = 0; w = 32'd0; m_req = 0;
    if (!m_out && !m_hb) begin
      if (src) m_pc = ta;
      else begin m_req = 1; m_addr = m_pc; m_out = 1; m_disc = 0; end
    end else if (m_hb) begin
      if (src) begin m_hb = 0; m_pc = ta; end
      else if (!st) begin deliver = 1; w = m_buf; m_hb = 0; end
    end else if (m_disc) begin
      if (src) m_pc = ta;
      if (rv) m_out = 0;
    end else begin
      if (rv) begin
        m_out = 0;
        if (src) m_pc = ta;
        else if (!st) begin deliver = 1; w = rd; end
        else begin m_hb = 1; m_buf = rd; end
      end else if (src) begin
        m_pc = ta; m_disc = 1;
      end
    end
    dpc = m_pc;
    if (deliver) m_pc = m_pc + 32'd4;
    if (fl) begin m_instr = NOP; m_valid = 0; end
    else if (st) begin end
    else if (deliver) begin
      m_instr = w; m_pcd = dpc; m_pc4 = dpc + 32'd4; m_valid = 1;
    end else begin m_instr = NOP; m_valid = 0; end
  endtask

  initial begin
    logic        mem_busy, rv, r, st, fl, src;
    logic [31:0] mem_addr, rd, tgt;
    int          mem_cnt;

    rst = 1; imem_rvalid = 0; imem_rdata = 0; stall_d = 0; flush_d = 0;
    pc_src_e = 0; pc_target_e = 0;
    @(negedge clk);

    // Basic stream, stall/HOLD, DROP, same-cycle redirect, flush, reset, wrap.
    tbl.push_back(mk(1,0,0,0,0,0,0,            0,32'h0,NOP,32'h0,32'h0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,            1,32'h0,NOP,32'h0,32'h0,0));
    tbl.push_back(mk(0,1,W0,0,0,0,0,           0,32'h0,W0,32'h0,32'h4,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,            1,32'h4,NOP,32'h0,32'h4,0));
    tbl.push_back(mk(0,1,W1,0,0,0,0,           0,32'h4,W1,32'h4,32'h8,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,            1,32'h8,NOP,32'h4,32'h8,0));
    tbl.push_back(mk(0,1,W2,0,0,0,0,           0,32'h8,W2,32'h8,32'hC,1));
    tbl.push_back(mk(1,0,0,0,0,0,0,            0,32'h0,NOP,32'h0,32'h0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,            1,32'h0,NOP,32'h0,32'h0,0));
    tbl.push_back(mk(0,1,W0,0,0,0,0,           0,32'h0,W0,32'h0,32'h4,1));
    tbl.push_back(mk(0,0,0,1,0,0,0,            1,32'h4,W0,32'h0,32'h4,1));
    tbl.push_back(mk(0,1,W1,1,0,0,0,           0,32'h4,W0,32'h0,32'h4,1));
    tbl.push_back(mk(0,0,0,1,0,0,0,            0,32'h4,W0,32'h0,32'h4,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,            0,32'h4,W1,32'h4,32'h8,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,            1,32'h8,NOP,32'h4,32'h8,0));
    tbl.push_back(mk(0,0,0,0,0,1,32'h42,       0,32'h8,NOP,32'h4,32'h8,0));
    tbl.push_back(mk(0,1,W2,0,0,0,0,           0,32'h8,NOP,32'h4,32'h8,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,            1,32'h40,NOP,32'h4,32'h8,0));
    tbl.push_back(mk(0,1,32'h00100513,0,0,0,0, 0,32'h40,32'h00100513,32'h40,32'h44,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,            1,32'h44,NOP,32'h40,32'h44,0));
    tbl.push_back(mk(0,1,32'hDEADBEEF,0,0,1,32'h100, 0,32'h44,NOP,32'h40,32'h44,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,            1,32'h100,NOP,32'h40,32'h44,0));
    tbl.push_back(mk(0,1,32'h00C00193,0,0,0,0, 0,32'h100,32'h00C00193,32'h100,32'h104,1));
    tbl.push_back(mk(0,0,0,1,1,0,0,            1,32'h104,NOP,32'h100,32'h104,0));
    tbl.push_back(mk(0,1,32'h00208233,0,0,0,0, 0,32'h104,32'h00208233,32'h104,32'h108,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,            1,32'h108,NOP,32'h104,32'h108,0));
    tbl.push_back(mk(1,0,0,0,0,0,0,            0,32'h0,NOP,32'h0,32'h0,0));
    tbl.push_back(mk(0,1,32'hBAD00000,0,0,0,0, 1,32'h0,NOP,32'h0,32'h0,0));
    tbl.push_back(mk(0,1,W0,0,0,0,0,           0,32'h0,W0,32'h0,32'h4,1));
    tbl.push_back(mk(0,0,0,0,0,1,32'hFFFFFFFF, 0,32'h0,NOP,32'h0,32'h4,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,            1,32'hFFFFFFFC,NOP,32'h0,32'h4,0));
    tbl.push_back(mk(0,1,32'h00000073,0,0,0,0, 0,32'hFFFFFFFC,32'h73,32'hFFFFFFFC,32'h0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0,            1,32'h0,NOP,32'hFFFFFFFC,32'h0,0));
    tbl.push_back(mk(0,0,0,1,0,0,0,            0,32'h0,NOP,32'hFFFFFFFC,32'h0,0));
    tbl.push_back(mk(0,1,32'h12345678,1,0,0,0, 0,32'h0,NOP,32'hFFFFFFFC,32'h0,0));
    tbl.push_back(mk(0,0,0,0,0,1,32'h200,      0,32'h0,NOP,32'hFFFFFFFC,32'h0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,            1,32'h200,NOP,32'hFFFFFFFC,32'h0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, tbl[i].rv, tbl[i].rdata, tbl[i].st, tbl[i].fl,
            tbl[i].src, tbl[i].tgt);
      chk($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].instr,
          tbl[i].pcd, tbl[i].pc4, tbl[i].valid);
    end

    // Redirects while in DROP keep updating the PC; a load under flush is
    // lost from IF/ID but still advances the fetch PC.
    apply(0,0,0,0,0,1,32'h300);
    chk("drop_enter", 0, 32'h200, NOP, 32'hFFFFFFFC, 32'h0, 0);
    apply(0,0,0,0,0,1,32'h400);
    chk("drop_redirect", 0, 32'h200, NOP, 32'hFFFFFFFC, 32'h0, 0);
    apply(0,1,32'hCAFEF00D,0,0,0,0);
    chk("drop_discard", 0, 32'h200, NOP, 32'hFFFFFFFC, 32'h0, 0);
    apply(0,0,0,0,0,0,0);
    chk("drop_refetch", 1, 32'h400, NOP, 32'hFFFFFFFC, 32'h0, 0);
    apply(0,1,32'h00500293,0,0,0,0);
    chk("drop_load", 0, 32'h400, 32'h00500293, 32'h400, 32'h404, 1);
    apply(0,0,0,0,0,0,0);
    chk("flush_fetch", 1, 32'h404, NOP, 32'h400, 32'h404, 0);
    apply(0,1,32'h00600313,0,1,0,0);
    chk("flush_on_load", 0, 32'h404, NOP, 32'h400, 32'h404, 0);
    apply(0,0,0,0,0,0,0);
    chk("flush_pc_adv", 1, 32'h408, NOP, 32'h400, 32'h404, 0);

    // Random phase against the reference model with a variable-latency memory.
    mem_busy = 0; mem_cnt = 0; mem_addr = 0;
    m_req = 0; m_addr = 0;
    for (int c = 0; c < 3000; c++) begin
      r   = (c == 0) || ($urandom_range(199) == 0);
      st  = ($urandom_range(99) < 30);
      fl  = ($urandom_range(99) < 8);
      src = ($urandom_range(99) < 8);
      tgt = ($urandom_range(7) == 0) ? (32'hFFFFFFFC | 32'($urandom_range(3)))
                                     : $urandom;
      rv = 0; rd = $urandom;
      if (mem_busy) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          rv = 1; rd = mem_addr ^ 32'hA5A5_0013; mem_busy = 0;
        end
      end
      if (m_req) begin
        mem_busy = 1; mem_cnt = $urandom_range(3, 1); mem_addr = m_addr;
      end
      apply(r, rv, rd, st, fl, src, tgt);
      model_step(r, rv, rd, st, fl, src, tgt);
      chk($sformatf("rand%0d", c), m_req, m_addr, m_instr, m_pcd, m_pc4, m_valid);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
